// File: rtl/hamming15_serial_tx.sv
// hamming15_serial_tx
// Hamming(15,11) even-parity encoder with a serial, LSB-first (position 1 first)
// valid/ready output stream. One word is accepted in IDLE, then its codeword is
// shifted out one bit per accepted tx beat while in SEND.
// Optional build macro OVERALL_PARITY_EN: appends an overall parity bit
// (position 0, XOR of positions 1..15) as a 16th bit after position 15, giving SECDED.
module hamming15_serial_tx (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [10:0] in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        tx_bit,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        tx_last,
   output logic        busy
);

`ifdef OVERALL_PARITY_EN
   localparam int FRAME_LEN = 16;
`else
   localparam int FRAME_LEN = 15;
`endif

   localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   logic [0:0]           r_state;
   logic [FRAME_LEN-1:0] r_shift;
   logic [3:0]           r_idx;

   logic [14:0]          w_cw;
   logic [FRAME_LEN-1:0] w_code;
   logic                 w_bit_accept;
   logic                 w_at_last;

   // Codeword bit c[i] holds position i+1; parity k covers positions with index bit k set.
   function automatic logic [14:0] hamming_encode(input logic [10:0] d);
      logic [14:0] c;
      c       = '0;
      c[2]    = d[0];
      c[4]    = d[1];
      c[5]    = d[2];
      c[6]    = d[3];
      c[8]    = d[4];
      c[9]    = d[5];
      c[10]   = d[6];
      c[11]   = d[7];
      c[12]   = d[8];
      c[13]   = d[9];
      c[14]   = d[10];
      // p1: positions 3,5,7,9,11,13,15
      c[0]    = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
      // p2: positions 3,6,7,10,11,14,15
      c[1]    = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
      // p4: positions 5,6,7,12,13,14,15
      c[3]    = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
      // p8: positions 9..15
      c[7]    = ^d[10:4];
      return c;
   endfunction

   assign w_cw = hamming_encode(in_data);

`ifdef OVERALL_PARITY_EN
   // Position 0 is sent last, so it sits above position 15 in the shift register.
   assign w_code = {^w_cw, w_cw};
`else
   assign w_code = w_cw;
`endif

   assign in_ready     = (r_state == ST_IDLE);
   assign tx_valid     = (r_state == ST_SEND);
   assign busy         = (r_state == ST_SEND);
   assign tx_bit       = r_shift[0];
   assign w_at_last    = (r_idx == LAST_IDX);
   assign tx_last      = tx_valid && w_at_last;
   assign w_bit_accept = tx_valid && tx_ready;

   // Frame FSM: latch codeword in IDLE, shift one bit out per accepted beat in SEND.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_shift <= w_code;
                  r_idx   <= '0;
                  r_state <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (w_bit_accept) begin
                  // Zeros shift in, so tx_bit reads 0 once the frame is drained.
                  r_shift <= r_shift >> 1;
                  if (w_at_last) begin
                     r_idx   <= '0;
                     r_state <= ST_IDLE;
                  end else begin
                     r_idx   <= r_idx + 4'd1;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hamming15_serial_tx.sv
// Directed bench for hamming15_serial_tx: known codewords, stalls, mid-frame
// reset and back-to-back words. Works with or without OVERALL_PARITY_EN.
module tb_hamming15_serial_tx;

`ifdef OVERALL_PARITY_EN
   localparam int FL = 16;
   localparam logic [FL-1:0] E000 = 16'h0000;
   localparam logic [FL-1:0] E7FF = 16'hFFFF;
   localparam logic [FL-1:0] E001 = 16'h8007;
   localparam logic [FL-1:0] E400 = 16'hC08B;
`else
   localparam int FL = 15;
   localparam logic [FL-1:0] E000 = 15'h0000;
   localparam logic [FL-1:0] E7FF = 15'h7FFF;
   localparam logic [FL-1:0] E001 = 15'h0007;
   localparam logic [FL-1:0] E400 = 15'h408B;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [10:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        tx_bit;
   logic        tx_valid;
   logic        tx_ready;
   logic        tx_last;
   logic        busy;

   int checks = 0;
   int errors = 0;

   hamming15_serial_tx dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .tx_bit   (tx_bit),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .tx_last  (tx_last),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one word in IDLE; keep in_valid high afterwards when keep=1.
   task automatic offer(input string tag, input logic [10:0] data, input bit keep);
      chk({tag, "_in_ready_idle"}, 32'(in_ready), 32'd1);
      in_data  = data;
      in_valid = 1'b1;
      step();
      if (!keep) in_valid = 1'b0;
      chk({tag, "_latency_valid"}, 32'(tx_valid), 32'd1);
      chk({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   // Collect one frame; stall=1 drives tx_ready as 1,0,0,1,0,0,...
   task automatic collect(input string tag, input logic [FL-1:0] exp, input bit stall);
      logic [FL-1:0] got;
      int  nacc;
      int  ncyc;
      bit  last_ok;
      bit  hold_ok;
      bit  ctrl_ok;
      bit  prev_stalled;
      logic held_bit;
      got = '0;
      nacc = 0;
      ncyc = 0;
      last_ok = 1'b1;
      hold_ok = 1'b1;
      ctrl_ok = 1'b1;
      prev_stalled = 1'b0;
      held_bit = 1'b0;
      while (nacc < FL && ncyc < 200) begin
         tx_ready = stall ? ((ncyc % 3) == 0) : 1'b1;
         if (!(tx_valid === 1'b1 && busy === 1'b1 && in_ready === 1'b0)) ctrl_ok = 1'b0;
         if (prev_stalled && tx_bit !== held_bit) hold_ok = 1'b0;
         if (tx_last !== (nacc == FL - 1)) last_ok = 1'b0;
         if (tx_ready) begin
            got[nacc] = tx_bit;
            nacc++;
            prev_stalled = 1'b0;
         end else begin
            prev_stalled = 1'b1;
            held_bit = tx_bit;
         end
         step();
         ncyc++;
      end
      tx_ready = 1'b1;
      chk({tag, "_bits_accepted"}, 32'(nacc), 32'(FL));
      chk({tag, "_frame"}, 32'(got), 32'(exp));
      chk({tag, "_cycles"}, 32'(ncyc), stall ? 32'(3 * (FL - 1) + 1) : 32'(FL));
      chk({tag, "_tx_last_ok"}, 32'(last_ok), 32'd1);
      chk({tag, "_hold_ok"}, 32'(hold_ok), 32'd1);
      chk({tag, "_ctrl_ok"}, 32'(ctrl_ok), 32'd1);
      chk({tag, "_end_tx_valid"}, 32'(tx_valid), 32'd0);
      chk({tag, "_end_in_ready"}, 32'(in_ready), 32'd1);
      chk({tag, "_end_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int nval;
      rst_n    = 1'b0;
      in_data  = 11'h7FF;
      in_valid = 1'b1;
      tx_ready = 1'b1;
      step();
      step();
      // Reset wins over an offered word.
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tx_bit", 32'(tx_bit), 32'd0);
      chk("rst_tx_last", 32'(tx_last), 32'd0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      step();
      chk("idle_tx_valid", 32'(tx_valid), 32'd0);

      offer("w000", 11'h000, 1'b0);
      collect("w000", E000, 1'b0);

      offer("w7ff", 11'h7FF, 1'b0);
      collect("w7ff", E7FF, 1'b0);

      offer("w001", 11'h001, 1'b0);
      collect("w001", E001, 1'b0);

      offer("w400s", 11'h400, 1'b0);
      collect("w400s", E400, 1'b1);

      // Mid-frame reset after the 7th accepted bit.
      offer("wrst", 11'h7FF, 1'b0);
      nval = 0;
      for (int i = 0; i < 7; i++) begin
         if (tx_valid === 1'b1) nval++;
         step();
      end
      chk("mid_valid_count", 32'(nval), 32'd7);
      rst_n = 1'b0;
      tx_ready = 1'b1;
      step();
      chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_tx_last", 32'(tx_last), 32'd0);
      rst_n = 1'b1;
      step();
      chk("post_rst_tx_valid", 32'(tx_valid), 32'd0);
      offer("after_rst", 11'h001, 1'b0);
      collect("after_rst", E001, 1'b0);

      // Back-to-back: second word stays pending until the IDLE gap cycle.
      offer("b2b_a", 11'h001, 1'b1);
      in_data = 11'h400;
      collect("b2b_a", E001, 1'b0);
      offer("b2b_b", 11'h400, 1'b0);
      collect("b2b_b", E400, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
